// File: rtl/int_closest_hit.sv
//------------------------------------------------------------------------------
// Module      : int_closest_hit
// Description : Streams per-lane triangle-test results and reduces them to the
//               closest valid hit of each ray. Optional drain statistics are
//               enabled by defining INT_CLOSEST_HIT_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module int_closest_hit #(
    parameter int NUM_LANES = 2,
    parameter int RAYID_W   = 8,
    parameter int TRIID_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [RAYID_W-1:0]           in_rayID,
    input  logic [31:0]                  in_tmax,
    input  logic [NUM_LANES-1:0]         in_hit,
    input  logic [32*NUM_LANES-1:0]      in_t,
    input  logic [TRIID_W*NUM_LANES-1:0] in_triID,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [RAYID_W-1:0]           out_rayID,
    output logic                         out_hit,
    output logic [31:0]                  out_t,
    output logic [TRIID_W-1:0]           out_triID,
    output logic                         err
`ifdef INT_CLOSEST_HIT_STATS_EN
    ,
    output logic [31:0]                  stat_rays,
    output logic [31:0]                  stat_hits
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [RAYID_W-1:0]   r_ray_id;
    logic [31:0]          r_tmax;
    logic                 r_acc_hit;
    logic [31:0]          r_acc_t;
    logic [TRIID_W-1:0]   r_acc_id;

    logic                 w_accept;
    logic                 w_mismatch;
    logic                 w_take;
    logic [30:0]          w_bound_mag;
    logic [31:0]          w_tmax_eff;

    logic [31:0]          w_lane_t  [NUM_LANES];
    logic [TRIID_W-1:0]   w_lane_id [NUM_LANES];
    logic [NUM_LANES-1:0] w_qual;

    logic                 w_best_hit;
    logic [31:0]          w_best_t;
    logic [TRIID_W-1:0]   w_best_id;

    logic                 w_res_hit;
    logic [31:0]          w_res_t;
    logic [TRIID_W-1:0]   w_res_id;

    // A held result blocks input; a draining result frees the slot this cycle.
    assign in_ready   = !(out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_mismatch = (r_state == S_ACC) && (in_rayID != r_ray_id);
    assign w_take     = w_accept && !w_mismatch;

    // tmax is only sampled on the first beat of a ray.
    assign w_tmax_eff  = (r_state == S_IDLE) ? in_tmax : r_tmax;
    assign w_bound_mag = (r_state == S_ACC && r_acc_hit) ? r_acc_t[30:0] : w_tmax_eff[30:0];

    // Positive, non-zero floats order like their magnitude bits as unsigned ints.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign w_lane_t[i]  = in_t[32*i +: 32];
        assign w_lane_id[i] = in_triID[TRIID_W*i +: TRIID_W];
        assign w_qual[i]    = in_hit[i]
                            && !w_lane_t[i][31]
                            && (|w_lane_t[i][30:0])
                            && (w_lane_t[i][30:0] < w_bound_mag);
    end

    // Strict compare in ascending lane order keeps the lowest lane on ties.
    always_comb begin
        w_best_hit = 1'b0;
        w_best_t   = '0;
        w_best_id  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_qual[i] && (!w_best_hit || (w_lane_t[i][30:0] < w_best_t[30:0]))) begin
                w_best_hit = 1'b1;
                w_best_t   = w_lane_t[i];
                w_best_id  = w_lane_id[i];
            end
        end
    end

    // Beat lanes were already bounded by the accumulator, so any beat hit is strictly closer.
    always_comb begin
        w_res_hit = 1'b0;
        w_res_t   = w_tmax_eff;
        w_res_id  = '0;
        if (w_best_hit) begin
            w_res_hit = 1'b1;
            w_res_t   = w_best_t;
            w_res_id  = w_best_id;
        end else if (r_state == S_ACC && r_acc_hit) begin
            w_res_hit = 1'b1;
            w_res_t   = r_acc_t;
            w_res_id  = r_acc_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take && !in_last) w_state_nxt = S_ACC;
            S_ACC:   if (w_take &&  in_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ray_id  <= '0;
            r_tmax    <= '0;
            r_acc_hit <= 1'b0;
            r_acc_t   <= '0;
            r_acc_id  <= '0;
        end else if (w_take) begin
            if (in_last) begin
                r_acc_hit <= 1'b0;
                r_acc_t   <= '0;
                r_acc_id  <= '0;
            end else begin
                r_acc_hit <= w_res_hit;
                r_acc_t   <= w_res_t;
                r_acc_id  <= w_res_id;
                if (r_state == S_IDLE) begin
                    r_ray_id <= in_rayID;
                    r_tmax   <= in_tmax;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rayID <= '0;
            out_hit   <= 1'b0;
            out_t     <= '0;
            out_triID <= '0;
        end else if (w_take && in_last) begin
            out_valid <= 1'b1;
            out_rayID <= in_rayID;
            out_hit   <= w_res_hit;
            out_t     <= w_res_t;
            out_triID <= w_res_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (w_accept && w_mismatch) begin
            err <= 1'b1;
        end
    end

`ifdef INT_CLOSEST_HIT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rays <= '0;
            stat_hits <= '0;
        end else if (out_valid && out_ready) begin
            stat_rays <= stat_rays + 32'd1;
            if (out_hit) begin
                stat_hits <= stat_hits + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_int_closest_hit.sv
//------------------------------------------------------------------------------
// Module      : tb_int_closest_hit
// Description : Directed self-checking bench for int_closest_hit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_closest_hit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [7:0]  in_rayID;
    logic [31:0] in_tmax;
    logic [1:0]  in_hit;
    logic [63:0] in_t;
    logic [31:0] in_triID;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_rayID;
    logic        out_hit;
    logic [31:0] out_t;
    logic [15:0] out_triID;
    logic        err;
`ifdef INT_CLOSEST_HIT_STATS_EN
    logic [31:0] stat_rays;
    logic [31:0] stat_hits;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    int_closest_hit #(
        .NUM_LANES (2),
        .RAYID_W   (8),
        .TRIID_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_rayID  (in_rayID),
        .in_tmax   (in_tmax),
        .in_hit    (in_hit),
        .in_t      (in_t),
        .in_triID  (in_triID),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rayID (out_rayID),
        .out_hit   (out_hit),
        .out_t     (out_t),
        .out_triID (out_triID),
        .err       (err)
`ifdef INT_CLOSEST_HIT_STATS_EN
        ,
        .stat_rays (stat_rays),
        .stat_hits (stat_hits)
`endif
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_beat(input logic v, input logic last, input logic [7:0] ray,
                            input logic [31:0] tmax, input logic [1:0] hit,
                            input logic [31:0] t0, input logic [31:0] t1,
                            input logic [15:0] id0, input logic [15:0] id1);
        in_valid = v;
        in_last  = last;
        in_rayID = ray;
        in_tmax  = tmax;
        in_hit   = hit;
        in_t     = {t1, t0};
        in_triID = {id1, id0};
    endtask

    task automatic idle;
        set_beat(1'b0, 1'b0, 8'd0, 32'd0, 2'b00, 32'd0, 32'd0, 16'd0, 16'd0);
    endtask

    task automatic test_reset;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL reset_out_hit: got %b expected 0", out_hit); end
        n_checks++; if (out_t !== 32'h0) begin n_fail++; $display("FAIL reset_out_t: got %h expected 0", out_t); end
        n_checks++; if (out_triID !== 16'h0) begin n_fail++; $display("FAIL reset_out_triID: got %h expected 0", out_triID); end
        n_checks++; if (out_rayID !== 8'h0) begin n_fail++; $display("FAIL reset_out_rayID: got %h expected 0", out_rayID); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_single_beat;
        set_beat(1'b1, 1'b1, 8'd1, 32'h42C80000, 2'b11, 32'h40A00000, 32'h40400000, 16'd7, 16'd9);
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL single_hit: got %b expected 1", out_hit); end
        n_checks++; if (out_t !== 32'h40400000) begin n_fail++; $display("FAIL single_t: got %h expected 40400000", out_t); end
        n_checks++; if (out_triID !== 16'd9) begin n_fail++; $display("FAIL single_triID: got %0d expected 9", out_triID); end
        n_checks++; if (out_rayID !== 8'd1) begin n_fail++; $display("FAIL single_rayID: got %0d expected 1", out_rayID); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_tie;
        set_beat(1'b1, 1'b0, 8'd2, 32'h42C80000, 2'b01, 32'h40A00000, 32'h0, 16'd3, 16'd0);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tie_early_valid: got %b expected 0", out_valid); end
        set_beat(1'b1, 1'b1, 8'd2, 32'h42C80000, 2'b10, 32'h0, 32'h40A00000, 16'd0, 16'd4);
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL tie_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL tie_hit: got %b expected 1", out_hit); end
        n_checks++; if (out_t !== 32'h40A00000) begin n_fail++; $display("FAIL tie_t: got %h expected 40a00000", out_t); end
        n_checks++; if (out_triID !== 16'd3) begin n_fail++; $display("FAIL tie_triID: got %0d expected 3", out_triID); end
        tick();
    endtask

    task automatic test_miss;
        set_beat(1'b1, 1'b1, 8'd3, 32'h42C80000, 2'b11, 32'hBF800000, 32'h42F00000, 16'd1, 16'd2);
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b expected 0", out_hit); end
        n_checks++; if (out_t !== 32'h42C80000) begin n_fail++; $display("FAIL miss_t: got %h expected 42c80000", out_t); end
        n_checks++; if (out_triID !== 16'd0) begin n_fail++; $display("FAIL miss_triID: got %0d expected 0", out_triID); end
        tick();
    endtask

    task automatic test_bound;
        // t equal to tmax and t of zero both fail to qualify
        set_beat(1'b1, 1'b1, 8'd4, 32'h40400000, 2'b11, 32'h40400000, 32'h00000000, 16'd5, 16'd6);
        tick();
        idle();
        n_checks++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL bound_eq_hit: got %b expected 0", out_hit); end
        n_checks++; if (out_t !== 32'h40400000) begin n_fail++; $display("FAIL bound_eq_t: got %h expected 40400000", out_t); end
        tick();
        // later-beat in_tmax must be ignored; bound becomes the accumulated t
        set_beat(1'b1, 1'b0, 8'd4, 32'h42C80000, 2'b01, 32'h40000000, 32'h0, 16'd1, 16'd0);
        tick();
        set_beat(1'b1, 1'b1, 8'd4, 32'h3F000000, 2'b11, 32'h40400000, 32'h3F800000, 16'd2, 16'd3);
        tick();
        idle();
        n_checks++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL bound_acc_hit: got %b expected 1", out_hit); end
        n_checks++; if (out_t !== 32'h3F800000) begin n_fail++; $display("FAIL bound_acc_t: got %h expected 3f800000", out_t); end
        n_checks++; if (out_triID !== 16'd3) begin n_fail++; $display("FAIL bound_acc_triID: got %0d expected 3", out_triID); end
        tick();
        set_beat(1'b1, 1'b0, 8'd4, 32'h41000000, 2'b00, 32'h0, 32'h0, 16'd0, 16'd0);
        tick();
        set_beat(1'b1, 1'b1, 8'd4, 32'h3F000000, 2'b00, 32'h0, 32'h0, 16'd0, 16'd0);
        tick();
        idle();
        n_checks++; if (out_t !== 32'h41000000) begin n_fail++; $display("FAIL bound_miss_tmax: got %h expected 41000000", out_t); end
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        set_beat(1'b1, 1'b1, 8'd3, 32'h42C80000, 2'b01, 32'h3F800000, 32'h0, 16'h11, 16'h0);
        tick();
        set_beat(1'b1, 1'b1, 8'd4, 32'h42C80000, 2'b10, 32'h0, 32'h3F000000, 16'h0, 16'h22);
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, out_valid); end
            n_checks++; if (out_t !== 32'h3F800000) begin n_fail++; $display("FAIL bp_t[%0d]: got %h expected 3f800000", k, out_t); end
            n_checks++; if (out_triID !== 16'h11) begin n_fail++; $display("FAIL bp_triID[%0d]: got %h expected 11", k, out_triID); end
            n_checks++; if (out_rayID !== 8'd3) begin n_fail++; $display("FAIL bp_rayID[%0d]: got %0d expected 3", k, out_rayID); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_rayID !== 8'd4) begin n_fail++; $display("FAIL bp_next_rayID: got %0d expected 4", out_rayID); end
        n_checks++; if (out_triID !== 16'h22) begin n_fail++; $display("FAIL bp_next_triID: got %h expected 22", out_triID); end
        n_checks++; if (out_t !== 32'h3F000000) begin n_fail++; $display("FAIL bp_next_t: got %h expected 3f000000", out_t); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_ray_mismatch;
        set_beat(1'b1, 1'b0, 8'd5, 32'h42C80000, 2'b01, 32'h40000000, 32'h0, 16'h55, 16'h0);
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mm_err_before: got %b expected 0", err); end
        set_beat(1'b1, 1'b1, 8'd6, 32'h42C80000, 2'b01, 32'h3F800000, 32'h0, 16'h66, 16'h0);
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mm_err_set: got %b expected 1", err); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mm_no_output: got %b expected 0", out_valid); end
        set_beat(1'b1, 1'b1, 8'd5, 32'h42C80000, 2'b00, 32'h0, 32'h0, 16'h0, 16'h0);
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mm_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_rayID !== 8'd5) begin n_fail++; $display("FAIL mm_rayID: got %0d expected 5", out_rayID); end
        n_checks++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL mm_hit: got %b expected 1", out_hit); end
        n_checks++; if (out_t !== 32'h40000000) begin n_fail++; $display("FAIL mm_t: got %h expected 40000000", out_t); end
        n_checks++; if (out_triID !== 16'h55) begin n_fail++; $display("FAIL mm_triID: got %h expected 55", out_triID); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mm_err_sticky: got %b expected 1", err); end
        tick();
    endtask

    task automatic test_reset_mid_ray;
        set_beat(1'b1, 1'b0, 8'd7, 32'h42C80000, 2'b01, 32'h3F800000, 32'h0, 16'h77, 16'h0);
        tick();
        set_beat(1'b1, 1'b1, 8'd7, 32'h42C80000, 2'b01, 32'h3F800000, 32'h0, 16'h77, 16'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_valid: got %b expected 0", out_valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmr_err: got %b expected 0", err); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_valid_late: got %b expected 0", out_valid); end
        set_beat(1'b1, 1'b1, 8'd8, 32'h40800000, 2'b00, 32'h0, 32'h0, 16'h0, 16'h0);
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmr_new_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_rayID !== 8'd8) begin n_fail++; $display("FAIL rmr_new_rayID: got %0d expected 8", out_rayID); end
        n_checks++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL rmr_new_hit: got %b expected 0", out_hit); end
        n_checks++; if (out_t !== 32'h40800000) begin n_fail++; $display("FAIL rmr_new_t: got %h expected 40800000", out_t); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmr_new_err: got %b expected 0", err); end
        tick();
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(1'b1, 1'b1, 8'(16 + k), 32'h42C80000, 2'b01, 32'h3F800000, 32'h0, 16'(256 + k), 16'h0);
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, out_valid); end
            n_checks++; if (out_rayID !== 8'(16 + k)) begin n_fail++; $display("FAIL b2b_rayID[%0d]: got %0d expected %0d", k, out_rayID, 16 + k); end
            n_checks++; if (out_triID !== 16'(256 + k)) begin n_fail++; $display("FAIL b2b_triID[%0d]: got %0d expected %0d", k, out_triID, 256 + k); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready); end
        end
        idle();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
    endtask

`ifdef INT_CLOSEST_HIT_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (stat_rays !== 32'd0) begin n_fail++; $display("FAIL stats_reset_rays: got %0d expected 0", stat_rays); end
        n_checks++; if (stat_hits !== 32'd0) begin n_fail++; $display("FAIL stats_reset_hits: got %0d expected 0", stat_hits); end
        for (int k = 0; k < 10; k++) begin
            set_beat(1'b1, 1'b1, 8'(k), 32'h42C80000, (k < 4) ? 2'b01 : 2'b00, 32'h3F800000, 32'h0, 16'(k), 16'h0);
            tick();
        end
        idle();
        tick();
        n_checks++; if (stat_rays !== 32'd10) begin n_fail++; $display("FAIL stats_rays: got %0d expected 10", stat_rays); end
        n_checks++; if (stat_hits !== 32'd4) begin n_fail++; $display("FAIL stats_hits: got %0d expected 4", stat_hits); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_tie();
        test_miss();
        test_bound();
        test_backpressure();
        test_ray_mismatch();
        test_reset_mid_ray();
        test_back_to_back();
`ifdef INT_CLOSEST_HIT_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
